// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI4 write arbiter: one burst in flight, AW -> len+1 W beats -> B routed back.
// One idle cycle of arbitration per burst; all payloads are combinational muxes, so backpressure passes straight through.
module axi_wr_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  localparam int IDX_W = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ),
  localparam int AW_W  = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
  localparam int W_W   = AXI_DATA_WIDTH + AXI_STRB_WIDTH + 1,
  localparam int B_W   = AXI_ID_WIDTH + 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      s_aw_valid_i,
  output logic [NUM_REQ-1:0]      s_aw_ready_o,
  input  logic [NUM_REQ*AW_W-1:0] s_aw_pld_i,
  input  logic [NUM_REQ-1:0]      s_w_valid_i,
  output logic [NUM_REQ-1:0]      s_w_ready_o,
  input  logic [NUM_REQ*W_W-1:0]  s_w_pld_i,
  output logic [NUM_REQ-1:0]      s_b_valid_o,
  input  logic [NUM_REQ-1:0]      s_b_ready_i,
  output logic [B_W-1:0]          s_b_pld_o,
  output logic                    m_aw_valid_o,
  input  logic                    m_aw_ready_i,
  output logic [AW_W-1:0]         m_aw_pld_o,
  output logic                    m_w_valid_o,
  input  logic                    m_w_ready_i,
  output logic [W_W-1:0]          m_w_pld_o,
  input  logic                    m_b_valid_i,
  output logic                    m_b_ready_o,
  input  logic [B_W-1:0]          m_b_pld_i,
  output logic [IDX_W-1:0]        gnt_o,
  output logic                    busy_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {IDLE, AW, DATA, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, gnt_nxt, pick, cand;
  logic [IDX_W:0]   sum;
  logic             found;
  logic [7:0]       cnt, cnt_nxt;
  logic             err_nxt;
  logic [AW_W-1:0]  aw_sel;
  logic [W_W-1:0]   w_sel;
  logic             w_vld_sel;
  logic             w_hs;

  // Payload muxes use constant slices so the select width never has to match the bus width.
  always_comb begin
    aw_sel    = '0;
    w_sel     = '0;
    w_vld_sel = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_o == IDX_W'(k)) begin
        aw_sel    = s_aw_pld_i[k*AW_W +: AW_W];
        w_sel     = s_w_pld_i[k*W_W +: W_W];
        w_vld_sel = s_w_valid_i[k];
      end
    end
  end

  // First requester at or after the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && s_aw_valid_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign w_hs   = w_vld_sel && m_w_ready_i;
  assign busy_o = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt_o;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    err_nxt      = err_o;
    s_aw_ready_o = '0;
    s_w_ready_o  = '0;
    s_b_valid_o  = '0;
    s_b_pld_o    = '0;
    m_aw_valid_o = 1'b0;
    m_aw_pld_o   = '0;
    m_w_valid_o  = 1'b0;
    m_w_pld_o    = '0;
    m_b_ready_o  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt   = pick;
          state_nxt = AW;
        end
      end
      AW: begin
        m_aw_valid_o        = 1'b1;
        m_aw_pld_o          = aw_sel;
        s_aw_ready_o[gnt_o] = m_aw_ready_i;
        if (m_aw_ready_i) begin
          cnt_nxt   = aw_sel[12:5];
          state_nxt = DATA;
        end
      end
      DATA: begin
        m_w_valid_o        = w_vld_sel;
        s_w_ready_o[gnt_o] = m_w_ready_i;
        // Downstream last comes from the beat counter, never from the requester.
        m_w_pld_o          = {w_sel[W_W-1:1], (cnt == 8'd0)};
        if (w_hs) begin
          if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
          else             state_nxt = RESP;
          if (w_sel[0] != (cnt == 8'd0)) err_nxt = 1'b1;
        end
      end
      RESP: begin
        s_b_valid_o[gnt_o] = m_b_valid_i;
        m_b_ready_o        = s_b_ready_i[gnt_o];
        s_b_pld_o          = m_b_pld_i;
        if (m_b_valid_i && s_b_ready_i[gnt_o]) begin
          ptr_nxt   = (gnt_o == IDX_W'(NUM_REQ-1)) ? '0 : gnt_o + 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt_o <= '0;
      ptr   <= '0;
      cnt   <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt_o <= gnt_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      err_o <= err_nxt;
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: expected AW/W/B transfers queued at drive time, checked by a negedge monitor.
module tb_axi_wr_arbiter;
  localparam int NUM_REQ = 2;
  localparam int IDX_W   = 1;
  localparam int AW_W    = 4 + 32 + 13;
  localparam int W_W     = 64 + 8 + 1;
  localparam int B_W     = 4 + 2;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [NUM_REQ-1:0]      s_aw_valid_i, s_aw_ready_o;
  logic [NUM_REQ*AW_W-1:0] s_aw_pld_i;
  logic [NUM_REQ-1:0]      s_w_valid_i, s_w_ready_o;
  logic [NUM_REQ*W_W-1:0]  s_w_pld_i;
  logic [NUM_REQ-1:0]      s_b_valid_o, s_b_ready_i;
  logic [B_W-1:0]          s_b_pld_o;
  logic                    m_aw_valid_o, m_aw_ready_i;
  logic [AW_W-1:0]         m_aw_pld_o;
  logic                    m_w_valid_o, m_w_ready_i;
  logic [W_W-1:0]          m_w_pld_o;
  logic                    m_b_valid_i, m_b_ready_o;
  logic [B_W-1:0]          m_b_pld_i;
  logic [IDX_W-1:0]        gnt_o;
  logic                    busy_o, err_o;

  axi_wr_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o), .s_aw_pld_i(s_aw_pld_i),
    .s_w_valid_i(s_w_valid_i), .s_w_ready_o(s_w_ready_o), .s_w_pld_i(s_w_pld_i),
    .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i), .s_b_pld_o(s_b_pld_o),
    .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i), .m_aw_pld_o(m_aw_pld_o),
    .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i), .m_w_pld_o(m_w_pld_o),
    .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o), .m_b_pld_i(m_b_pld_i),
    .gnt_o(gnt_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  logic exp_err = 1'b0;
  logic [AW_W-1:0]      exp_aw[$];
  logic [W_W-1:0]       exp_w[$];
  logic [IDX_W+B_W-1:0] exp_b[$];
  logic [AW_W-1:0]      mon_aw;
  logic [W_W-1:0]       mon_w;
  logic [IDX_W+B_W-1:0] mon_b;
  logic [NUM_REQ-1:0]   mon_bv;

  // Handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk_i) begin
    if (!rst_i && m_aw_valid_o && m_aw_ready_i) begin
      tests++;
      if (exp_aw.size() == 0) begin
        fails++; $display("FAIL aw_unexpected: got %h, expected no AW", m_aw_pld_o);
      end else begin
        mon_aw = exp_aw.pop_front();
        if (m_aw_pld_o !== mon_aw) begin
          fails++; $display("FAIL aw_payload: got %h, expected %h", m_aw_pld_o, mon_aw);
        end
      end
    end
    if (!rst_i && m_w_valid_o && m_w_ready_i) begin
      tests++;
      if (exp_w.size() == 0) begin
        fails++; $display("FAIL w_unexpected: got %h, expected no beat", m_w_pld_o);
      end else begin
        mon_w = exp_w.pop_front();
        if (m_w_pld_o !== mon_w) begin
          fails++; $display("FAIL w_beat: got %h, expected %h", m_w_pld_o, mon_w);
        end
      end
    end
    if (!rst_i && |(s_b_valid_o & s_b_ready_i)) begin
      tests++;
      if (exp_b.size() == 0) begin
        fails++; $display("FAIL b_unexpected: got valid %b pld %h", s_b_valid_o, s_b_pld_o);
      end else begin
        mon_b  = exp_b.pop_front();
        mon_bv = '0;
        mon_bv[mon_b[B_W +: IDX_W]] = 1'b1;
        if (s_b_valid_o !== mon_bv || s_b_pld_o !== mon_b[B_W-1:0]) begin
          fails++;
          $display("FAIL b_resp: got valid %b pld %h, expected valid %b pld %h",
                   s_b_valid_o, s_b_pld_o, mon_bv, mon_b[B_W-1:0]);
        end
      end
    end
  end

  task automatic raise_aw(input int r, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    logic [AW_W-1:0] p;
    p = {id, addr, len, 3'd3, 2'b01};
    s_aw_pld_i[r*AW_W +: AW_W] = p;
    s_aw_valid_i[r] = 1'b1;
    exp_aw.push_back(p);
  endtask

  // Carries requester r through AW, nbeats W beats and (if complete) the B response.
  task automatic serve(input int r, input int len, input int bad_beat, input int nbeats,
                       input int aw_stall, input bit wtoggle, input logic [3:0] bid, input logic [1:0] bresp);
    logic [AW_W-1:0] pld0;
    logic [63:0] d;
    logic [7:0]  st;
    logic        last_exp, hs;
    int n;
    m_aw_ready_i = (aw_stall == 0);
    @(negedge clk_i);
    n = 0;
    while (!m_aw_valid_o && n < 50) begin @(negedge clk_i); n++; end
    tests++;
    if (n >= 50) begin fails++; $display("FAIL aw_timeout: got no m_aw_valid, expected within 50 cycles"); end
    else if (gnt_o !== IDX_W'(r)) begin fails++; $display("FAIL grant: got %0d, expected %0d", gnt_o, r); end
    pld0 = m_aw_pld_o;
    for (int s = 0; s < aw_stall; s++) begin
      tests++;
      if (m_aw_pld_o !== pld0 || s_aw_ready_o !== '0 || m_aw_valid_o !== 1'b1) begin
        fails++; $display("FAIL aw_hold: got pld %h rdy %b vld %b, expected pld %h rdy 0 vld 1",
                          m_aw_pld_o, s_aw_ready_o, m_aw_valid_o, pld0);
      end
      @(posedge clk_i); #1;
      if (s == aw_stall - 1) m_aw_ready_i = 1'b1;
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    s_aw_valid_i[r] = 1'b0;
    m_aw_ready_i = 1'b1;

    m_w_ready_i = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      d  = {$urandom, $urandom};
      st = 8'($urandom);
      last_exp = (b == len);
      exp_w.push_back({d, st, last_exp});
      s_w_pld_i[r*W_W +: W_W] = {d, st, last_exp ^ (b == bad_beat)};
      s_w_valid_i[r] = 1'b1;
      n = 0; hs = 1'b0;
      while (!hs && n < 100) begin
        @(negedge clk_i);
        hs = s_w_ready_o[r];
        @(posedge clk_i); #1;
        if (wtoggle) m_w_ready_i = ~m_w_ready_i;
        n++;
      end
      s_w_valid_i[r] = 1'b0;
      if (b == bad_beat) exp_err = 1'b1;
      tests++;
      if (!hs) begin fails++; $display("FAIL w_timeout: beat %0d not accepted, expected within 100 cycles", b); end
      else if (err_o !== exp_err) begin fails++; $display("FAIL err_flag: beat %0d got %b, expected %b", b, err_o, exp_err); end
    end
    m_w_ready_i = 1'b1;
    if (nbeats != len + 1) return;

    exp_b.push_back({IDX_W'(r), bid, bresp});
    m_b_valid_i = 1'b1;
    m_b_pld_i = {bid, bresp};
    s_b_ready_i[r] = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!s_b_valid_o[r] && n < 50) begin @(negedge clk_i); n++; end
    tests++;
    if (s_b_valid_o !== (NUM_REQ'(1) << r)) begin
      fails++; $display("FAIL b_route: got %b, expected %b", s_b_valid_o, NUM_REQ'(1) << r);
    end
    @(posedge clk_i); #1;
    m_b_valid_i = 1'b0;
    m_b_pld_i = '0;
    s_b_ready_i = '0;
    tests++;
    if (busy_o !== 1'b0 || exp_w.size() != 0 || exp_b.size() != 0) begin
      fails++; $display("FAIL burst_end: got busy %b w_left %0d b_left %0d, expected 0 0 0",
                        busy_o, exp_w.size(), exp_b.size());
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    s_aw_valid_i = '1; s_aw_pld_i = {$urandom, $urandom};
    s_w_valid_i = '1;  s_w_pld_i = {$urandom, $urandom, $urandom};
    s_b_ready_i = '0;  m_aw_ready_i = 1'b1; m_w_ready_i = 1'b1;
    m_b_valid_i = 1'b1; m_b_pld_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    tests++;
    if ({gnt_o, busy_o, err_o} !== '0) begin
      fails++; $display("FAIL reset_state: got gnt %0d busy %b err %b, expected 0 0 0", gnt_o, busy_o, err_o);
    end
    tests++;
    if ({s_aw_ready_o, s_w_ready_o, s_b_valid_o, m_aw_valid_o, m_w_valid_o, m_b_ready_o} !== '0) begin
      fails++; $display("FAIL reset_handshake: got %b, expected all 0",
                        {s_aw_ready_o, s_w_ready_o, s_b_valid_o, m_aw_valid_o, m_w_valid_o, m_b_ready_o});
    end
    tests++;
    if ({m_aw_pld_o, m_w_pld_o, s_b_pld_o} !== '0) begin
      fails++; $display("FAIL reset_payload: got aw %h w %h b %h, expected 0", m_aw_pld_o, m_w_pld_o, s_b_pld_o);
    end
    s_aw_valid_i = '0; s_w_valid_i = '0; m_b_valid_i = 1'b0;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_single_burst;
    raise_aw(0, 4'h2, 32'h0000_1000, 8'd3);
    @(negedge clk_i);
    tests++;
    if (busy_o !== 1'b0 || m_aw_valid_o !== 1'b0) begin
      fails++; $display("FAIL arb_latency: got busy %b aw_vld %b, expected 0 0", busy_o, m_aw_valid_o);
    end
    serve(0, 3, -1, 4, 0, 1'b0, 4'h5, 2'b00);
  endtask

  task automatic test_contention;
    raise_aw(1, 4'h7, 32'h0000_2000, 8'd0);
    serve(1, 0, -1, 1, 0, 1'b0, 4'h7, 2'b01);
    for (int round = 0; round < 2; round++) begin
      raise_aw(0, 4'h1, 32'h0000_3000 + 32'(round), 8'd1);
      raise_aw(1, 4'h9, 32'h0000_4000 + 32'(round), 8'd2);
      serve(0, 1, -1, 2, 0, 1'b0, 4'h1, 2'b00);
      serve(1, 2, -1, 3, 0, 1'b0, 4'h9, 2'b10);
      tests++;
      if (gnt_o !== 1'b1 || busy_o !== 1'b0 || exp_aw.size() != 0) begin
        fails++; $display("FAIL gnt_hold: got gnt %0d busy %b aw_left %0d, expected 1 0 0",
                          gnt_o, busy_o, exp_aw.size());
      end
    end
  endtask

  task automatic test_backpressure;
    raise_aw(0, 4'h3, 32'hDEAD_0040, 8'd3);
    serve(0, 3, -1, 4, 5, 1'b1, 4'h3, 2'b00);
  endtask

  task automatic test_last_mismatch;
    tests++;
    if (err_o !== 1'b0) begin fails++; $display("FAIL err_pre: got %b, expected 0", err_o); end
    raise_aw(1, 4'hA, 32'h0000_5000, 8'd1);
    serve(1, 1, 0, 2, 0, 1'b0, 4'hA, 2'b11);
  endtask

  task automatic test_reset_mid;
    raise_aw(0, 4'h4, 32'h0000_6000, 8'd3);
    serve(0, 3, -1, 2, 0, 1'b0, 4'h0, 2'b00);
    tests++;
    if (busy_o !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b, expected 1", busy_o); end
    rst_i = 1'b1;
    #1;
    tests++;
    if ({busy_o, gnt_o, err_o, m_w_valid_o, s_w_ready_o, s_aw_ready_o, s_b_valid_o, m_b_ready_o} !== '0
        || m_w_pld_o !== '0) begin
      fails++; $display("FAIL reset_mid: got busy %b gnt %0d err %b w_vld %b w_rdy %b pld %h, expected all 0",
                        busy_o, gnt_o, err_o, m_w_valid_o, s_w_ready_o, m_w_pld_o);
    end
    exp_w.delete(); exp_b.delete(); exp_aw.delete();
    exp_err = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    raise_aw(1, 4'hC, 32'h0000_7000, 8'd2);
    serve(1, 2, -1, 3, 0, 1'b0, 4'hC, 2'b00);
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_contention();
    test_backpressure();
    test_last_mismatch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Shares one AXI4 write path (AW/W/B) between NUM_REQ upstream masters, one burst in flight at a time.
- Round-robin grant per burst; AW, then exactly len+1 W beats, then B is routed back to the granted requester.
- Output side drives the master-side write signals of an AXI_BUS master port.
- Read channels are out of scope.

Parameters:
- NUM_REQ, 2, number of requesters (≥2); IDX_W = max(1, $clog2(NUM_REQ)).
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width.
- AXI_ID_WIDTH, 4, ID width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width.
- Derived: AW_W = AXI_ID_WIDTH+AXI_ADDR_WIDTH+13, packed {id,addr,len[7:0],size[2:0],burst[1:0]}; W_W = AXI_DATA_WIDTH+AXI_STRB_WIDTH+1, packed {data,strb,last}; B_W = AXI_ID_WIDTH+2, packed {id,resp}. Requester i occupies slice i of every packed vector.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- s_aw_valid_i  in  NUM_REQ  per-requester AW valid.
- s_aw_ready_o  out  NUM_REQ  per-requester AW ready.
- s_aw_pld_i  in  NUM_REQ*AW_W  AW payloads.
- s_w_valid_i  in  NUM_REQ  W valid.
- s_w_ready_o  out  NUM_REQ  W ready.
- s_w_pld_i  in  NUM_REQ*W_W  W payloads.
- s_b_valid_o  out  NUM_REQ  B valid.
- s_b_ready_i  in  NUM_REQ  B ready.
- s_b_pld_o  out  B_W  B payload, broadcast to all requesters.
- m_aw_valid_o  out  1  downstream AW valid.
- m_aw_ready_i  in  1  downstream AW ready.
- m_aw_pld_o  out  AW_W  downstream AW payload.
- m_w_valid_o  out  1  downstream W valid.
- m_w_ready_i  in  1  downstream W ready.
- m_w_pld_o  out  W_W  downstream W payload; the last bit is regenerated by the beat counter.
- m_b_valid_i  in  1  downstream B valid.
- m_b_ready_o  out  1  downstream B ready.
- m_b_pld_i  in  B_W  downstream B payload.
- gnt_o  out  IDX_W  current or last granted index.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- err_o  out  1  sticky: upstream w_last disagreed with the beat count.

Behaviour:
- Reset values: state IDLE; gnt_o=0; rr pointer=0; beat counter=0; err_o=0. All valid/ready outputs 0; payload outputs 0.
- IDLE:
  - If any s_aw_valid_i is set, grant the first set bit at or after the rr pointer, wrapping at NUM_REQ.
  - Register the grant into gnt_o and go to AW. Arbitration costs exactly one cycle.
- AW:
  - m_aw_valid_o=1; m_aw_pld_o = slice gnt; s_aw_ready_o[gnt] = m_aw_ready_i; all other readies 0.
  - On handshake: latch len into a beat counter (load len) and go to DATA.
- DATA:
  - m_w_valid_o = s_w_valid_i[gnt]; s_w_ready_o[gnt] = m_w_ready_i; data and strb are passed from slice gnt.
  - m_w last bit = (counter==0), independent of the upstream last bit.
  - On each W handshake: if counter≠0, decrement.
  - Also on each W handshake, if upstream last ≠ (counter==0), set err_o.
  - The handshake with counter==0 goes to RESP.
  - len=0 means a single beat.
- RESP:
  - s_b_valid_o[gnt] = m_b_valid_i; m_b_ready_o = s_b_ready_i[gnt]; s_b_pld_o = m_b_pld_i.
  - On B handshake: rr pointer = gnt+1 (wrap to 0 at NUM_REQ), go to IDLE.
- No payload is buffered; all datapaths are combinational through the mux; only state, gnt, pointer, counter and err are registered.
- W beats presented before their AW is accepted are held off (ready=0). This is legal AXI slave behaviour.
- Non-granted requesters see ready=0 and b_valid=0 at all times.
- A requester dropping s_aw_valid_i after IDLE grants it is an upstream protocol violation; the FSM still waits in AW.
- s_b_pld_o is driven in every state; it is only meaningful when the corresponding s_b_valid_o is set.
- busy_o=1 in AW, DATA and RESP.
- Reset asserted mid-burst: immediate return to reset values; no B is issued for the aborted burst; err_o clears.
- err_o clears only on reset.

Test Plan:
- Single burst: req0 AW len=3, 4 W beats with correct last, downstream B resp=OKAY id=5 -> 4 m_w handshakes, last only on beat 4, s_b_valid_o=01, payload {5,0}, busy_o returns 0.
- Contention: req0 and req1 both valid in IDLE, pointer=0 -> req0 is served first, then req1. Third round with both valid again -> req0 (pointer=0 after req1).
- Backpressure: m_aw_ready_i low 5 cycles, m_w_ready_i toggling every other cycle -> AW payload held stable, no beats lost, 4 beats total for len=3.
- Last mismatch: len=1, upstream asserts last on beat 1 -> err_o=1 from the next cycle; m_w last still asserted only on beat 2; burst completes.
- Reset mid-DATA: assert rst_i after 2 of 4 beats -> all outputs 0 at once, state IDLE; a fresh req1 burst then completes normally.
